// File: rtl/transfer_pkg.sv
// Shared types and encodings for the DataTransfer instruction controller.
package transfer_pkg;

   // Controller sequence: one state per datapath step of an instruction.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      LOAD_AB = 3'd2,
      EXEC    = 3'd3,
      LOAD_C  = 3'd4,
      WRBACK  = 3'd5,
      DONE    = 3'd6
   } state_t;

   // Legal ALU operations; every other code is rejected with err.
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;

   // ABus source select codes.
   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_C    = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

endpackage

// File: rtl/transfer_ctrl.sv
// Sequences one register-file instruction through the DataTransfer datapath:
// read operands, latch A/B, run the ALU, latch C, write the result back.
// Every control output is a decode of registered state, so reset forces the
// idle values immediately and no output depends combinationally on inputs.
module transfer_ctrl
   import transfer_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned OP_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OP_W-1:0]   op_in,
   input  logic [ADDR_W-1:0] src1_in,
   input  logic [ADDR_W-1:0] src2_in,
   input  logic [ADDR_W-1:0] dst_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] ReadAddr1,
   output logic [ADDR_W-1:0] ReadAddr2,
   output logic              LD_A,
   output logic              LD_B,
   output logic              LD_C,
   output logic              OEA,
   output logic              OEB,
   output logic              OEC,
   output logic              enableALU,
   output logic [OP_W-1:0]   opcode,
   output logic [1:0]        SelMux,
   output logic              WriteEnable,
   output logic [ADDR_W-1:0] WriteAddr,
   output logic [7:0]        instr_cnt
);

   state_t            r_state;
   state_t            w_state_next;
   logic [OP_W-1:0]   r_op;
   logic [ADDR_W-1:0] r_src1;
   logic [ADDR_W-1:0] r_src2;
   logic [ADDR_W-1:0] r_dst;
   logic              r_illegal;
   logic [7:0]        r_instr_cnt;
   logic              w_op_legal;
   logic              w_accept;

   // Legality is judged on the requested op at capture time.
   assign w_op_legal = (op_in == OP_W'(OP_ADD)) ||
                       (op_in == OP_W'(OP_SUB)) ||
                       (op_in == OP_W'(OP_MUL));

   // A request is only taken in IDLE; starts while busy or in DONE are dropped.
   assign w_accept = (r_state == IDLE) && start;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: fixed walk for legal ops, READ->DONE shortcut otherwise.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_next = READ;
         READ:    w_state_next = r_illegal ? DONE : LOAD_AB;
         LOAD_AB: w_state_next = EXEC;
         EXEC:    w_state_next = LOAD_C;
         LOAD_C:  w_state_next = WRBACK;
         WRBACK:  w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Instruction capture: fields are frozen for the whole instruction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op      <= '0;
         r_src1    <= '0;
         r_src2    <= '0;
         r_dst     <= '0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_op      <= op_in;
         r_src1    <= src1_in;
         r_src2    <= src2_in;
         r_dst     <= dst_in;
         r_illegal <= !w_op_legal;
      end
   end

   // Completed-instruction counter; rejected ops do not count, wraps at 255.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_instr_cnt <= 8'd0;
      end else if ((r_state == DONE) && !r_illegal) begin
         r_instr_cnt <= r_instr_cnt + 8'd1;
      end
   end

   assign instr_cnt = r_instr_cnt;

   // Output decode from the registered state and captured fields.
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      ReadAddr1   = '0;
      ReadAddr2   = '0;
      LD_A        = 1'b0;
      LD_B        = 1'b0;
      LD_C        = 1'b0;
      OEA         = 1'b1;
      OEB         = 1'b1;
      OEC         = 1'b1;
      enableALU   = 1'b0;
      opcode      = '0;
      SelMux      = SEL_NONE;
      WriteEnable = 1'b0;
      WriteAddr   = '0;
      unique case (r_state)
         IDLE: begin
         end
         READ: begin
            busy      = 1'b1;
            ReadAddr1 = r_src1;
            ReadAddr2 = r_src2;
         end
         LOAD_AB: begin
            busy      = 1'b1;
            ReadAddr1 = r_src1;
            ReadAddr2 = r_src2;
            LD_A      = 1'b1;
            LD_B      = 1'b1;
         end
         EXEC: begin
            busy      = 1'b1;
            ReadAddr1 = r_src1;
            ReadAddr2 = r_src2;
            enableALU = 1'b1;
            opcode    = r_op;
         end
         LOAD_C: begin
            busy      = 1'b1;
            ReadAddr1 = r_src1;
            ReadAddr2 = r_src2;
            enableALU = 1'b1;
            opcode    = r_op;
            LD_C      = 1'b1;
         end
         WRBACK: begin
            // Only C drives the ABus here, so the OE one-hot rule holds.
            busy        = 1'b1;
            ReadAddr1   = r_src1;
            ReadAddr2   = r_src2;
            OEC         = 1'b0;
            SelMux      = SEL_C;
            WriteEnable = 1'b1;
            WriteAddr   = r_dst;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
            err  = r_illegal;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_transfer_ctrl.sv
// Directed bench for transfer_ctrl: a vector table walked cycle by cycle
// against a per-state expectation, plus hand sequences for held start,
// mid-instruction reset and counter wrap.
module tb_transfer_ctrl;
   import transfer_pkg::*;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned OP_W   = 3;

   logic              clk;
   logic              rst;
   logic              start;
   logic [OP_W-1:0]   op_in;
   logic [ADDR_W-1:0] src1_in;
   logic [ADDR_W-1:0] src2_in;
   logic [ADDR_W-1:0] dst_in;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] ReadAddr1;
   logic [ADDR_W-1:0] ReadAddr2;
   logic              LD_A;
   logic              LD_B;
   logic              LD_C;
   logic              OEA;
   logic              OEB;
   logic              OEC;
   logic              enableALU;
   logic [OP_W-1:0]   opcode;
   logic [1:0]        SelMux;
   logic              WriteEnable;
   logic [ADDR_W-1:0] WriteAddr;
   logic [7:0]        instr_cnt;

   transfer_ctrl #(
      .ADDR_W (ADDR_W),
      .OP_W   (OP_W)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op_in       (op_in),
      .src1_in     (src1_in),
      .src2_in     (src2_in),
      .dst_in      (dst_in),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .ReadAddr1   (ReadAddr1),
      .ReadAddr2   (ReadAddr2),
      .LD_A        (LD_A),
      .LD_B        (LD_B),
      .LD_C        (LD_C),
      .OEA         (OEA),
      .OEB         (OEB),
      .OEC         (OEC),
      .enableALU   (enableALU),
      .opcode      (opcode),
      .SelMux      (SelMux),
      .WriteEnable (WriteEnable),
      .WriteAddr   (WriteAddr),
      .instr_cnt   (instr_cnt)
   );

   typedef struct packed {
      logic              busy;
      logic              done;
      logic              err;
      logic [ADDR_W-1:0] ra1;
      logic [ADDR_W-1:0] ra2;
      logic              ld_a;
      logic              ld_b;
      logic              ld_c;
      logic              oea;
      logic              oeb;
      logic              oec;
      logic              en_alu;
      logic [OP_W-1:0]   opc;
      logic [1:0]        sel;
      logic              we;
      logic [ADDR_W-1:0] wa;
   } obs_t;

   // Inputs plus the hand-derived outcome: rejection and done cycle offset.
   typedef struct {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] src1;
      logic [ADDR_W-1:0] src2;
      logic [ADDR_W-1:0] dst;
      logic              illegal;
      int                done_k;
   } vec_t;

   int         n_checks;
   int         n_fail;
   int         we_count;
   logic [7:0] exp_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Per-cycle output-enable one-hot check and write-strobe tally.
   always @(negedge clk) begin
      if (WriteEnable) we_count++;
      if (rst) begin
         n_checks++;
         if ($countones({OEA, OEB, OEC}) < 2) begin
            n_fail++;
            $display("FAIL oe_onehot: actual OEA/OEB/OEC=%b%b%b required at most one low",
                     OEA, OEB, OEC);
         end
      end
   end

   function automatic obs_t idle_obs();
      obs_t o;
      o     = '0;
      o.oea = 1'b1;
      o.oeb = 1'b1;
      o.oec = 1'b1;
      o.sel = SEL_NONE;
      return o;
   endfunction

   function automatic obs_t sample_obs();
      obs_t o;
      o.busy   = busy;
      o.done   = done;
      o.err    = err;
      o.ra1    = ReadAddr1;
      o.ra2    = ReadAddr2;
      o.ld_a   = LD_A;
      o.ld_b   = LD_B;
      o.ld_c   = LD_C;
      o.oea    = OEA;
      o.oeb    = OEB;
      o.oec    = OEC;
      o.en_alu = enableALU;
      o.opc    = opcode;
      o.sel    = SelMux;
      o.we     = WriteEnable;
      o.wa     = WriteAddr;
      return o;
   endfunction

   // Expected outputs k cycles after the edge that sampled start.
   function automatic obs_t exp_obs(input vec_t v, input int k);
      obs_t o;
      o = idle_obs();
      if (k >= 1 && k <= v.done_k) o.busy = 1'b1;
      if (k == v.done_k) begin
         o.done = 1'b1;
         o.err  = v.illegal;
      end
      if (v.illegal) begin
         if (k == 1) begin
            o.ra1 = v.src1;
            o.ra2 = v.src2;
         end
      end else begin
         if (k >= 1 && k <= 5) begin
            o.ra1 = v.src1;
            o.ra2 = v.src2;
         end
         if (k == 2) begin
            o.ld_a = 1'b1;
            o.ld_b = 1'b1;
         end
         if (k == 3 || k == 4) begin
            o.en_alu = 1'b1;
            o.opc    = v.op;
         end
         if (k == 4) o.ld_c = 1'b1;
         if (k == 5) begin
            o.oec = 1'b0;
            o.sel = SEL_C;
            o.we  = 1'b1;
            o.wa  = v.dst;
         end
      end
      return o;
   endfunction

   task automatic check_obs(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // Entered and left at a falling edge with the DUT idle.
   task automatic run_vec(input vec_t v, input string name);
      op_in   = v.op;
      src1_in = v.src1;
      src2_in = v.src2;
      dst_in  = v.dst;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      // Scramble inputs so only the captured copy can produce correct outputs.
      op_in   = ~v.op;
      src1_in = ~v.src1;
      src2_in = ~v.src2;
      dst_in  = ~v.dst;
      for (int k = 1; k <= v.done_k + 1; k++) begin
         @(negedge clk);
         check_obs($sformatf("%s_c%0d", name, k), sample_obs(), exp_obs(v, k));
      end
      if (!v.illegal) exp_cnt = exp_cnt + 8'd1;
      check_int({name, "_cnt"}, int'(instr_cnt), int'(exp_cnt));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_obs("reset_idle", sample_obs(), idle_obs());
      check_int("reset_cnt", int'(instr_cnt), 0);
      @(negedge clk);
      rst     = 1'b1;
      exp_cnt = 8'd0;
   endtask

   vec_t vecs[8];

   initial begin
      vec_t v;
      int   n_done;
      int   done_at[3];

      n_checks = 0;
      n_fail   = 0;
      we_count = 0;
      exp_cnt  = 8'd0;
      rst      = 1'b0;
      start    = 1'b0;
      op_in    = '0;
      src1_in  = '0;
      src2_in  = '0;
      dst_in   = '0;

      vecs[0] = '{op: 3'b001, src1: 5'd0,  src2: 5'd1,  dst: 5'd2,  illegal: 1'b0, done_k: 6};
      vecs[1] = '{op: 3'b010, src1: 5'd3,  src2: 5'd7,  dst: 5'd3,  illegal: 1'b0, done_k: 6};
      vecs[2] = '{op: 3'b011, src1: 5'd31, src2: 5'd30, dst: 5'd0,  illegal: 1'b0, done_k: 6};
      vecs[3] = '{op: 3'b111, src1: 5'd5,  src2: 5'd6,  dst: 5'd7,  illegal: 1'b1, done_k: 2};
      vecs[4] = '{op: 3'b000, src1: 5'd8,  src2: 5'd9,  dst: 5'd10, illegal: 1'b1, done_k: 2};
      vecs[5] = '{op: 3'b100, src1: 5'd11, src2: 5'd12, dst: 5'd13, illegal: 1'b1, done_k: 2};
      vecs[6] = '{op: 3'b001, src1: 5'd9,  src2: 5'd10, dst: 5'd10, illegal: 1'b0, done_k: 6};
      vecs[7] = '{op: 3'b101, src1: 5'd21, src2: 5'd22, dst: 5'd23, illegal: 1'b1, done_k: 2};

      // Reset values while rst is held low from time zero.
      #1;
      check_obs("por_idle", sample_obs(), idle_obs());
      check_int("por_cnt", int'(instr_cnt), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // start held for 20 sampled edges: completions at 6, 13 and 20 only.
      n_done  = 0;
      op_in   = OP_ADD;
      src1_in = 5'd1;
      src2_in = 5'd2;
      dst_in  = 5'd3;
      start   = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (done) begin
            if (n_done < 3) done_at[n_done] = c;
            n_done++;
         end
         if (c == 7 || c == 14) check_int($sformatf("held_idle_c%0d", c), int'(busy), 0);
      end
      start = 1'b0;
      check_int("held_done_count", n_done, 3);
      check_int("held_done_0", done_at[0], 6);
      check_int("held_done_1", done_at[1], 13);
      check_int("held_done_2", done_at[2], 20);
      @(negedge clk);
      exp_cnt = exp_cnt + 8'd3;
      check_int("held_cnt", int'(instr_cnt), int'(exp_cnt));

      // Counter wrap after 256 legal instructions.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         v.op      = OP_W'((i % 3) + 1);
         v.src1    = ADDR_W'(i);
         v.src2    = ADDR_W'(i + 7);
         v.dst     = ADDR_W'(i + 13);
         v.illegal = 1'b0;
         v.done_k  = 6;
         run_vec(v, $sformatf("wrap%0d", i));
         if (i == 254) check_int("wrap_255", int'(instr_cnt), 255);
      end
      check_int("wrap_zero", int'(instr_cnt), 0);

      // Reset asserted during EXEC aborts the write.
      op_in   = OP_SUB;
      src1_in = 5'd4;
      src2_in = 5'd5;
      dst_in  = 5'd6;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_int("exec_reached", int'(enableALU), 1);
      we_count = 0;
      #2;
      rst = 1'b0;
      #1;
      check_obs("abort_idle", sample_obs(), idle_obs());
      check_int("abort_cnt", int'(instr_cnt), 0);
      repeat (3) @(negedge clk);
      check_int("abort_no_we", we_count, 0);
      rst     = 1'b1;
      exp_cnt = 8'd0;
      v       = '{op: 3'b011, src1: 5'd4, src2: 5'd5, dst: 5'd6, illegal: 1'b0, done_k: 6};
      run_vec(v, "post_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/transfer_ctrl.md
TRANSFER_CTRL -- requirements
Module: transfer_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 5, register-file address width.
- OP_W, 3, ALU opcode width.
REQ-002 Ports SHALL be, clock and reset first (all control outputs drive the DataTransfer datapath):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  instruction request.
- op_in  in  OP_W  requested ALU operation.
- src1_in  in  ADDR_W  operand-1 address.
- src2_in  in  ADDR_W  operand-2 address.
- dst_in  in  ADDR_W  result address.
- busy  out  1  instruction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-opcode pulse.
- ReadAddr1  out  ADDR_W  register-file read address 1.
- ReadAddr2  out  ADDR_W  register-file read address 2.
- LD_A, LD_B, LD_C  out  1 each  register load strobes.
- OEA, OEB, OEC  out  1 each  tristate enables, active-low.
- enableALU  out  1  ALU enable.
- opcode  out  OP_W  ALU operation.
- SelMux  out  2  ABus source: 00 A, 01 B, 10 C, 11 none.
- WriteEnable  out  1  register-file write strobe.
- WriteAddr  out  ADDR_W  register-file write address.
- instr_cnt  out  8  completed-instruction counter.
REQ-003 Reset SHALL be asynchronous and active-low on rst; all state SHALL be clocked on rising clk.

Function
REQ-004 FSM states SHALL be: IDLE, READ, LOAD_AB, EXEC, LOAD_C, WRBACK, DONE.
REQ-005 In IDLE with start=1, op_in, src1_in, src2_in and dst_in SHALL be captured and the FSM SHALL go to READ. busy SHALL be 1 in every state except IDLE.
REQ-006 READ SHALL drive ReadAddr1=src1 and ReadAddr2=src2, and SHALL hold them through WRBACK.
REQ-007 LOAD_AB SHALL assert LD_A=1 and LD_B=1 for exactly one cycle.
REQ-008 EXEC SHALL assert enableALU=1 and drive opcode=captured op; enableALU and opcode SHALL stay asserted through LOAD_C.
REQ-009 LOAD_C SHALL assert LD_C=1 for one cycle.
REQ-010 WRBACK SHALL, for one cycle, drive:
- OEC=0 and SelMux=10;
- WriteEnable=1 and WriteAddr=dst.
REQ-011 DONE SHALL pulse done=1 for one cycle, increment instr_cnt (wrapping 255->0), then return to IDLE.
REQ-012 Fixed latency: done SHALL be high exactly 6 cycles after the cycle in which start was sampled in IDLE.
REQ-013 Outside the states above, outputs SHALL idle as follows:
- all strobes 0;
- OEA=OEB=OEC=1;
- SelMux=11;
- opcode=000.
REQ-014 Opcodes 001 (ADD), 010 (SUB) and 011 (MUL) are legal. Any other op SHALL go READ->DONE, pulse err=1 with done=1, issue no LD/WriteEnable, and leave instr_cnt unchanged.
REQ-015 start while busy=1 SHALL be ignored without buffering; start in the DONE cycle SHALL also be ignored.
REQ-016 dst equal to src1 or src2 SHALL be legal; the write SHALL occur only in WRBACK, after the operands are latched.
REQ-017 At most one of OEA, OEB and OEC SHALL be 0 in any cycle.

Reset
REQ-018 rst=0 SHALL immediately force:
- FSM to IDLE;
- busy=done=err=0;
- all strobes and enables 0;
- OEA=OEB=OEC=1, SelMux=11;
- instr_cnt=0;
- addresses and opcode 0.
REQ-019 Reset mid-instruction SHALL abort with no WriteEnable pulse; the first start after rst rises SHALL be accepted normally.

Structure
REQ-020 Package transfer_pkg SHALL hold:
- the state enum;
- OP_ADD=001, OP_SUB=010, OP_MUL=011;
- SelMux codes SEL_A, SEL_B, SEL_C, SEL_NONE.
REQ-021 The design SHALL be one module, with no sub-module; outputs SHALL be decoded from registered state only.

Verification
REQ-022 ADD: start with op=001, src1=0, src2=1, dst=2 -> LD_A/LD_B at cycle+2, LD_C at +4, WriteEnable with WriteAddr=2 and OEC=0 at +5, done at +6, instr_cnt=1.
REQ-023 Illegal op=111 -> done and err high together at +2, no LD or WriteEnable seen, instr_cnt unchanged.
REQ-024 start held high for 20 cycles -> exactly 3 instructions complete (at cycles 6, 13 and 20); no start is accepted in the DONE cycle.
REQ-025 rst driven low during EXEC -> outputs at idle values immediately, WriteEnable never asserted; next start completes in 6 cycles.
REQ-026 256 legal instructions -> instr_cnt wraps to 0; one-hot OE assertion checked on every cycle.
REQ-027 dst=src1=3 with op=010 -> read addresses stable through WRBACK, and the write follows LD_A.
